cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//   Three-stage pipelined WIDTH-bit adder/subtractor built from 8-bit carry-lookahead groups.
//   Stage 1 forms the bit generate/propagate vectors that the 8-bit lookahead unit consumes.
//   Stage 2 runs one 8-bit lookahead per group, then stage 3 ripples the group carries.
//   Serves as the mantissa add/sub datapath of the FPU, with valid/ready on both sides.
// PARAMETERS
//   WIDTH   32   operand width; must be a multiple of 8 and >= 8; GROUPS = WIDTH/8
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (ignored when sub=1)
//   sub        in   1      1: A - B (B inverted, carry-in forced to 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  A + B' + c, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB ^ cout
// BEHAVIOUR
//   Reset: all stage valid flags = 0. Outputs while rst is high: sum=0, cout=0, ovf=0, out_valid=0.
//     Reset takes effect immediately (async), including mid-operation. In-flight ops are dropped, not completed.
//     in_ready = 1 in the first cycle after rst deasserts.
//   Handshake:
//     - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
//     - out_valid and result must stay stable until taken.
//   Stall: stage k loads when (stage k empty) | (stage k+1 loads); the output stage counts as loading when out_ready.
//     in_ready = stage-1 load enable. This is combinational from out_ready, which is allowed.
//     Bubbles collapse: up to 3 ops are held while out_ready=0. Order is preserved; nothing is dropped or duplicated.
//   S1 (accept):
//     - bb = sub ? ~b : b; c0 = sub ? 1 : cin.
//     - Register G = a & bb, P = a ^ bb, and c0.
//   S2 (group): for each group j, compute 8-bit lookahead carries assuming Ci=0 and Ci=1.
//     - Form sum0_j = P_j ^ {carries(Ci=0)} and sum1_j = P_j ^ {carries(Ci=1)}.
//     - Group terms: Gx_j = group generate, Px_j = &P_j.
//     - Also keep the carry into bit 7 of the top group for Ci=0 and Ci=1.
//     - Register sum0, sum1, Gx, Px, c0, and the top-group bit-7 carries.
//   S3 (resolve):
//     - gc[0] = c0; gc[j+1] = Gx_j | Px_j & gc[j].
//     - Group j sum = gc[j] ? sum1_j : sum0_j.
//     - cout = gc[GROUPS]; ovf = selected MSB carry-in ^ cout.
//     - Register sum, cout, ovf; out_valid = S3 valid.
//   Latency: out_valid rises 3 clocks after the accepting edge, given no stall. Throughput: 1 op/clock.
//   Boundaries:
//     - All-ones propagate chains across every group resolve in S3, with no extra cycle.
//     - WIDTH=8 degenerates to a single group and must still build.
//     - in_valid & in_ready in the same cycle the output is taken while the pipe is full: accepted, no bubble.
// TESTING
//   - a=FFFFFFFF b=00000001 cin=0 sub=0 -> sum=00000000 cout=1 ovf=0; out_valid 3 clocks after accept.
//   - a=00000005 b=00000007 sub=1 -> sum=FFFFFFFE cout=0 ovf=0.
//     Same op with a=7, b=5 -> sum=00000002 cout=1.
//   - a=7FFFFFFF b=00000001 cin=0 -> sum=80000000 cout=0 ovf=1.
//     a=80000000 b=80000000 -> sum=0 cout=1 ovf=1.
//   - Issue 4 back-to-back ops with out_ready=0 from the start.
//     -> in_ready drops once 3 ops are held; the 4th is held off.
//     -> On out_ready=1, results appear in order, one per clock, with none lost.
//   - Assert rst with 2 ops in flight -> out_valid=0 and sum=0 immediately.
//     -> After release, in_ready=1 and no stale result ever appears.
//   - 10k random a/b/cin/sub with random in_valid/out_ready, checked against a reference model
//     of {cout,sum} = a + bb + c0 and of ovf. Include WIDTH=8 and WIDTH=64 builds.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: three-stage pipelined add/sub built from 8-bit carry-lookahead groups
// Stage 1 registers bit G/P, stage 2 forms per-group conditional sums, stage 3 resolves group carries.
module cla_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int GROUPS = WIDTH / 8;
  logic ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic c0_q, c0_d, c0b_q, c0b_d, t0_q, t0_d, t1_q, t1_d;
  logic [WIDTH-1:0] sum0_q, sum0_d, sum1_q, sum1_d, sum_q, sum_d;
  logic [GROUPS-1:0] gx_q, gx_d, px_q, px_d, gxc, pxc;
  logic [WIDTH-1:0] s0, s1, rs;
  logic [8:0] k0;
  logic [7:0] k1;
  logic [GROUPS:0] gc;
  logic cout_q, cout_d, ovf_q, ovf_d;
  always_comb begin : accept
    ld3 = !v3_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
    v1_d = ld1 ? in_valid : v1_q;
    v2_d = ld2 ? v1_q : v2_q;
    v3_d = ld3 ? v2_q : v3_q;
    g_d = ld1 ? a & (sub ? ~b : b) : g_q;
    p_d = ld1 ? a ^ (sub ? ~b : b) : p_q;
    c0_d = ld1 ? sub | cin : c0_q;
  end
  // k0/k1 are the in-group carries assuming carry-in 0 and 1; only k0 needs the group carry-out
  always_comb begin : group
    k0 = '0;
    k1 = '0;
    s0 = '0;
    s1 = '0;
    gxc = '0;
    pxc = '0;
    for (int j = 0; j < GROUPS; j++) begin
      k0[0] = 1'b0;
      k1[0] = 1'b1;
      for (int i = 0; i < 8; i++) k0[i+1] = g_q[8*j+i] | p_q[8*j+i] & k0[i];
      for (int i = 0; i < 7; i++) k1[i+1] = g_q[8*j+i] | p_q[8*j+i] & k1[i];
      s0[8*j +: 8] = p_q[8*j +: 8] ^ k0[7:0];
      s1[8*j +: 8] = p_q[8*j +: 8] ^ k1;
      gxc[j] = k0[8];
      pxc[j] = &p_q[8*j +: 8];
    end
    sum0_d = ld2 ? s0 : sum0_q;
    sum1_d = ld2 ? s1 : sum1_q;
    gx_d = ld2 ? gxc : gx_q;
    px_d = ld2 ? pxc : px_q;
    t0_d = ld2 ? k0[7] : t0_q;
    t1_d = ld2 ? k1[7] : t1_q;
    c0b_d = ld2 ? c0_q : c0b_q;
  end
  always_comb begin : resolve
    gc = '0;
    rs = '0;
    gc[0] = c0b_q;
    for (int j = 0; j < GROUPS; j++) begin
      gc[j+1] = gx_q[j] | px_q[j] & gc[j];
      rs[8*j +: 8] = gc[j] ? sum1_q[8*j +: 8] : sum0_q[8*j +: 8];
    end
    sum_d = ld3 ? rs : sum_q;
    cout_d = ld3 ? gc[GROUPS] : cout_q;
    ovf_d = ld3 ? (gc[GROUPS-1] ? t1_q : t0_q) ^ gc[GROUPS] : ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      g_q <= '0;
      p_q <= '0;
      c0_q <= 1'b0;
      sum0_q <= '0;
      sum1_q <= '0;
      gx_q <= '0;
      px_q <= '0;
      t0_q <= 1'b0;
      t1_q <= 1'b0;
      c0b_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      g_q <= g_d;
      p_q <= p_d;
      c0_q <= c0_d;
      sum0_q <= sum0_d;
      sum1_q <= sum1_d;
      gx_q <= gx_d;
      px_q <= px_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      c0b_q <= c0b_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = ld1;
  assign out_valid = v3_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed vectors and pipeline corner cases on a 32-bit instance,
// plus randomized traffic on 8/32/64-bit instances checked against an arithmetic model.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  typedef struct {
    logic [31:0] a, b;
    logic cin, sub;
    logic [31:0] s;
    logic c, o;
  } vec_t;
  vec_t vt[12];
  logic [31:0] sexp[4];
  int cnt;

  cla_pipe_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W = g == 0 ? 8 : g == 1 ? 32 : 64;
    logic r_rst, r_iv, r_ir, r_ov, r_or, r_cin, r_sub, r_cout, r_ovf;
    logic [W-1:0] r_a, r_b, r_sum;
    logic [W+1:0] q[$];
    logic done = 1'b0;
    cla_pipe_adder #(.WIDTH(W)) dut_r (
      .clk(clk), .rst(r_rst), .in_valid(r_iv), .in_ready(r_ir), .a(r_a), .b(r_b),
      .cin(r_cin), .sub(r_sub), .out_valid(r_ov), .out_ready(r_or),
      .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
    );
    initial begin
      int n;
      logic hold;
      logic [W+1:0] hv, exp;
      logic [W-1:0] bb;
      logic [W:0] full;
      n = 0;
      hold = 1'b0;
      hv = '0;
      r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
      repeat (3) @(negedge clk);
      r_rst = 1'b0;
      for (int cyc = 0; cyc < 40000 && n < 10000; cyc++) begin
        @(negedge clk);
        r_iv = $urandom_range(3) != 0;
        r_or = $urandom_range(3) != 0;
        r_a = W'({$urandom, $urandom});
        r_b = W'({$urandom, $urandom});
        if ($urandom_range(7) == 0) r_a = '1;
        if ($urandom_range(7) == 0) r_b = '1;
        r_cin = 1'($urandom);
        r_sub = 1'($urandom);
        #1;
        if (hold) check("rand_stable", 72'({r_ov, r_ovf, r_cout, r_sum}), 72'({1'b1, hv}));
        hold = r_ov && !r_or;
        hv = {r_ovf, r_cout, r_sum};
        if (r_ov && r_or) begin
          if (q.size() == 0) check("rand_spurious", 72'(r_ov), 72'(0));
          else begin
            exp = q.pop_front();
            check($sformatf("rand_w%0d", W), 72'({r_ovf, r_cout, r_sum}), 72'(exp));
            n++;
          end
        end
        if (r_iv && r_ir) begin
          bb = r_sub ? ~r_b : r_b;
          full = {1'b0, r_a} + {1'b0, bb} + (W+1)'(r_sub | r_cin);
          exp = {(r_a[W-1] == bb[W-1]) && (full[W-1] != r_a[W-1]), full};
          q.push_back(exp);
        end
      end
      if (n < 10000) check($sformatf("rand_timeout_w%0d", W), 72'(n), 72'(10000));
      done = 1'b1;
    end
  end

  initial begin
    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vt[6]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[7]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[8]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[9]  = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h21436587, 1'b0, 1'b0};
    vt[10] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000D, 1'b1, 1'b0};
    vt[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold", 72'({out_valid, cout, ovf, sum}), 72'(0));
    rst = 1'b0;
    #1 check("rdy_after_rst", 72'(in_ready), 72'(1));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("lat1", 72'(out_valid), 72'(0));
      @(negedge clk);
      check("lat2", 72'(out_valid), 72'(0));
      @(negedge clk);
      check($sformatf("vec%0d", i), 72'({out_valid, cout, ovf, sum}), 72'({1'b1, vt[i].c, vt[i].o, vt[i].s}));
    end
    // four back-to-back ops against a stalled consumer
    for (int k = 0; k < 4; k++) sexp[k] = 32'(k * 1000 + 17 + 256);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      a = 32'(k * 1000 + 17); b = 32'h100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      #1 check($sformatf("stall_rdy%0d", k), 72'(in_ready), 72'(k < 3));
    end
    repeat (2) begin
      @(negedge clk);
      #1 check("stall_hold", 72'({in_ready, out_valid, sum}), 72'({1'b0, 1'b1, sexp[0]}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("full_take_rdy", 72'(in_ready), 72'(1));
    check("stall_out0", 72'({out_valid, sum}), 72'({1'b1, sexp[0]}));
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 check($sformatf("stall_out%0d", k), 72'({out_valid, sum}), 72'({1'b1, sexp[k]}));
    end
    @(negedge clk);
    #1 check("stall_drained", 72'(out_valid), 72'(0));
    // reset with ops in flight and a result waiting at the output
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 32'(k + 40); b = 32'h55; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("pre_rst", 72'({out_valid, sum}), 72'({1'b1, 32'h7D}));
    #2 rst = 1'b1;
    #1 check("rst_async", 72'({out_valid, cout, ovf, sum}), 72'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 check("rdy_after_rst2", 72'(in_ready), 72'(1));
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (out_valid) cnt++;
    end
    check("no_stale", 72'(cnt), 72'(0));
    for (int i = 0; i < 60000 && !(rnd[0].done && rnd[1].done && rnd[2].done); i++) @(negedge clk);
    check("rand_done", 72'({rnd[0].done, rnd[1].done, rnd[2].done}), 72'(3'b111));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
